// File: rtl/module_name_block.sv
// module_name_block
//   Serial-to-parallel capture. D is an asynchronous serial input. It is passed
//   through a SYNC_STAGES-deep synchronizer and then assembled into MSB-first
//   frames of WIDTH bits. Frames are back-to-back, and their boundaries are fixed
//   by the instant nrst is released.
//
// Ports
//   clk      : system clock, rising edge
//   nrst     : asynchronous active-low reset
//   D        : serial data, asynchronous to clk, MSB first
//   q        : last completed frame, held until the next one completes
//   q_valid  : one-cycle strobe when q updates
//   q_parity : XOR of all bits of q, registered with q
`timescale 1ns/1ps
module module_name_block #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             D,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             q_parity
);

    localparam int CW = $clog2(WIDTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   d_s;
    logic [2:0]             warm;
    logic                   warm_done;
    logic [WIDTH-2:0]       shift;
    logic [CW-1:0]          cnt;
    logic                   cnt_last;
    logic [WIDTH-1:0]       frame;

    assign d_s       = sync[SYNC_STAGES-1];
    assign warm_done = (warm == 3'(SYNC_STAGES));
    assign cnt_last  = (cnt == CW'(WIDTH - 1));
    // Only the low WIDTH-1 bits of the shift path are ever observed, so the
    // register keeps just those bits. The full word is that register with d_s appended.
    assign frame     = {shift, d_s};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], D};
        end
    end

    // Holds framing off until the reset-state synchronizer contents have been flushed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            warm <= '0;
        end else if (!warm_done) begin
            warm <= warm + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (warm_done) begin
            shift <= frame[WIDTH-2:0];
            cnt   <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q        <= '0;
            q_valid  <= 1'b0;
            q_parity <= 1'b0;
        end else if (warm_done && cnt_last) begin
            q        <= frame;
            q_valid  <= 1'b1;
            q_parity <= ^frame;
        end else begin
            q_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_module_name_block.sv
`timescale 1ns/1ps
module tb_module_name_block;

    logic       clk   = 1'b0;
    logic       nrst  = 1'b0;
    logic       D     = 1'b0;
    logic       nrst2 = 1'b0;
    logic       D2    = 1'b0;
    logic [7:0] q;
    logic       qv, qp;
    logic [3:0] q2;
    logic       qv2, qp2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          edge_n;
        logic [31:0] data;
    } exp_t;

    exp_t        sb1[$];
    exp_t        sb2[$];
    exp_t        e1, e2, ep;
    int          edge1, edge2, frames1;
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;

    always #5 clk = ~clk;

    module_name_block #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .nrst(nrst), .D(D), .q(q), .q_valid(qv), .q_parity(qp)
    );

    module_name_block #(.WIDTH(4), .SYNC_STAGES(3)) dut4 (
        .clk(clk), .nrst(nrst2), .D(D2), .q(q2), .q_valid(qv2), .q_parity(qp2)
    );

    // Edge numbers relative to reset release: edge 1 is the first rising edge.
    always @(posedge clk or negedge nrst)
        if (!nrst) edge1 <= 0; else edge1 <= edge1 + 1;
    always @(posedge clk or negedge nrst2)
        if (!nrst2) edge2 <= 0; else edge2 <= edge2 + 1;

    always @(negedge nrst)  last1 = '0;
    always @(negedge nrst2) last2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a strobe appears; otherwise q must hold.
    always @(negedge clk) begin
        if (!nrst) begin
            chk("w8_rst_q", 32'(q), 32'h0);
            chk("w8_rst_valid", 32'(qv), 32'h0);
        end else if (qv) begin
            if (sb1.size() == 0) begin
                checks++; failures++;
                $display("FAIL w8_unexpected_valid actual=1 expected=0 edge=%0d q=0x%0h", edge1, q);
            end else begin
                e1 = sb1.pop_front();
                chk("w8_valid_edge", 32'(edge1), 32'(e1.edge_n));
                chk("w8_q", 32'(q), e1.data);
                chk("w8_parity", 32'(qp), 32'(^e1.data));
                last1 = e1.data;
            end
        end else begin
            chk("w8_q_hold", 32'(q), last1);
            chk("w8_parity_hold", 32'(qp), 32'(^last1));
        end
    end

    always @(negedge clk) begin
        if (!nrst2) begin
            chk("w4_rst_q", 32'(q2), 32'h0);
            chk("w4_rst_valid", 32'(qv2), 32'h0);
        end else if (qv2) begin
            if (sb2.size() == 0) begin
                checks++; failures++;
                $display("FAIL w4_unexpected_valid actual=1 expected=0 edge=%0d q=0x%0h", edge2, q2);
            end else begin
                e2 = sb2.pop_front();
                chk("w4_valid_edge", 32'(edge2), 32'(e2.edge_n));
                chk("w4_q", 32'(q2), e2.data);
                chk("w4_parity", 32'(qp2), 32'(^e2.data));
                last2 = e2.data;
            end
        end else begin
            chk("w4_q_hold", 32'(q2), last2);
            chk("w4_parity_hold", 32'(qp2), 32'(^last2));
        end
    end

    task automatic release1(input logic first_bit);
        @(negedge clk);
        D       = first_bit;
        nrst    = 1'b1;
        frames1 = 0;
    endtask

    // Drive the top nbits of v MSB first, one bit per cycle; push a full frame.
    task automatic send8(input logic [7:0] v, input int nbits, input bit push);
        for (int i = 7; i > 7 - nbits; i--) begin
            D = v[i];
            @(negedge clk);
        end
        if (push) begin
            ep.edge_n = 8 * frames1 + 8 + 2;
            ep.data   = 32'(v);
            sb1.push_back(ep);
            frames1++;
        end
    endtask

    task automatic async_reset_check1(input string tag);
        #2 nrst = 1'b0;
        #1;
        chk({tag, "_async_q"}, 32'(q), 32'h0);
        chk({tag, "_async_valid"}, 32'(qv), 32'h0);
        chk({tag, "_async_parity"}, 32'(qp), 32'h0);
    endtask

    task automatic drain1(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_all_frames_seen"}, 32'(sb1.size()), 32'h0);
        async_reset_check1(tag);
    endtask

    initial begin
        // Power-on reset
        #6;
        chk("por_q", 32'(q), 32'h0);
        chk("por_valid", 32'(qv), 32'h0);
        chk("por_parity", 32'(qp), 32'h0);
        #10;
        chk("por_q_cycle", 32'(q), 32'h0);
        chk("por_valid_cycle", 32'(qv), 32'h0);
        chk("por_parity_cycle", 32'(qp), 32'h0);

        // Single frame 0xA5, released at a falling edge
        release1(1'b1);
        #1.1;
        chk("rel_q", 32'(q), 32'h0);
        chk("rel_valid", 32'(qv), 32'h0);
        chk("rel_parity", 32'(qp), 32'h0);
        send8(8'hA5, 8, 1'b1);
        drain1("a5");

        // Odd-parity frame
        release1(1'b0);
        send8(8'h01, 8, 1'b1);
        drain1("odd");

        // Constant one: frames at edges 10, 18, 26
        release1(1'b1);
        send8(8'hFF, 8, 1'b1);
        send8(8'hFF, 8, 1'b1);
        send8(8'hFF, 8, 1'b1);
        drain1("ones");

        // Reset in the middle of the second frame, then a fresh frame
        release1(1'b1);
        send8(8'hFF, 8, 1'b1);
        send8(8'hFF, 4, 1'b0);
        async_reset_check1("midframe");
        release1(1'b0);
        send8(8'h3C, 8, 1'b1);
        drain1("3c");

        // WIDTH=4, SYNC_STAGES=3: 1,1,0,1 -> 0xD at edge 7
        @(negedge clk);
        D2    = 1'b1;
        nrst2 = 1'b1;
        begin
            logic [3:0] v4;
            v4 = 4'hD;
            for (int i = 3; i >= 0; i--) begin
                D2 = v4[i];
                @(negedge clk);
            end
            ep.edge_n = 7;
            ep.data   = 32'(v4);
            sb2.push_back(ep);
        end
        repeat (4) @(negedge clk);
        chk("w4_all_frames_seen", 32'(sb2.size()), 32'h0);
        #2 nrst2 = 1'b0;
        #1;
        chk("w4_async_q", 32'(q2), 32'h0);
        chk("w4_async_valid", 32'(qv2), 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
